// File: rtl/adc_spi_responder.sv
// SPI-side stand-in for the 8-channel 12-bit serial ADC: decodes the config word and shifts back results.
// Define ADC_RESP_RAMP_EN to replace iCH_DATA with an internal ramp that advances every completed frame.
module adc_spi_responder #(
  parameter int          CONV_CYCLES = 65,
  parameter logic [5:0]  RST_CFG     = 6'b100010
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iCS,
  input  logic        iSCLK,
  input  logic        iDIN,
  output logic        oDOUT,
  input  logic [95:0] iCH_DATA,
  output logic [5:0]  oCFG,
  output logic        oFRAME_DONE,
  output logic        oCONV_ERR
);

  // state | meaning
  // IDLE  | after reset, waiting for the first conversion request
  // CONV  | iCS high, timing the conversion
  // SHIFT | frame in progress: result out, config in
  // DONE  | frame complete, DOUT parked on bit 0 until next iCS rise
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  localparam int CW = $clog2(CONV_CYCLES + 1);

  state_t        state, state_nxt;
  logic [2:0]    cs_sync, sclk_sync;
  logic [1:0]    din_sync;
  logic          cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [CW-1:0] conv_cnt;
  logic [5:0]    cfg_shift;
  logic [2:0]    rise_cnt;
  logic [3:0]    fall_cnt;
  logic [11:0]   shift_reg;
  logic [11:0]   sample, load_word;
  logic          conv_short, enter_shift, enter_done;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      din_sync  <= '0;
    end else begin
      cs_sync   <= {cs_sync[1:0], iCS};
      sclk_sync <= {sclk_sync[1:0], iSCLK};
      din_sync  <= {din_sync[0], iDIN};
    end
  end

  assign cs_rise   =  cs_sync[1]   & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1]   &  cs_sync[2];
  assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // iCS rise has priority over any SCLK edge, aborting an unfinished frame
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = CONV;
    end else begin
      case (state)
        CONV:    if (cs_fall) state_nxt = SHIFT;
        SHIFT:   if (sclk_fall && fall_cnt == 4'd10) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

`ifdef ADC_RESP_RAMP_EN
  logic [11:0] ramp;
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)         ramp <= '0;
    else if (enter_done) ramp <= ramp + 12'd1;
  end
`endif

  always_comb begin
    enter_shift = (state == CONV)  && (state_nxt == SHIFT);
    enter_done  = (state == SHIFT) && (state_nxt == DONE);
    conv_short  = conv_cnt < CW'(CONV_CYCLES);
`ifdef ADC_RESP_RAMP_EN
    sample = ramp;
`else
    sample = 12'(iCH_DATA >> (32'(oCFG[4:2]) * 32'd12));
`endif
    // bipolar mode converts offset binary to two's complement
    if (conv_short)   load_word = 12'h000;
    else if (oCFG[1]) load_word = sample;
    else              load_word = sample ^ 12'h800;
  end

  // conv_cnt starts at 1 so an iCS high of exactly CONV_CYCLES clocks is valid
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      conv_cnt    <= '0;
      cfg_shift   <= '0;
      rise_cnt    <= '0;
      fall_cnt    <= '0;
      shift_reg   <= '0;
      oDOUT       <= 1'b0;
      oCFG        <= RST_CFG;
      oFRAME_DONE <= 1'b0;
      oCONV_ERR   <= 1'b0;
    end else begin
      oFRAME_DONE <= 1'b0;
      oCONV_ERR   <= 1'b0;
      if (cs_rise)
        conv_cnt <= CW'(1);
      else if (state == CONV && conv_short)
        conv_cnt <= conv_cnt + CW'(1);

      if (state_nxt == CONV) begin
        oDOUT <= 1'b0;
      end else if (enter_shift) begin
        shift_reg <= load_word;
        oDOUT     <= load_word[11];
        rise_cnt  <= '0;
        fall_cnt  <= '0;
        cfg_shift <= '0;
        oCONV_ERR <= conv_short;
      end else if (state == SHIFT) begin
        if (sclk_rise && rise_cnt < 3'd6) begin
          cfg_shift <= {cfg_shift[4:0], din_sync[1]};
          rise_cnt  <= rise_cnt + 3'd1;
        end
        if (sclk_fall) begin
          shift_reg <= {shift_reg[10:0], 1'b0};
          oDOUT     <= shift_reg[10];
          fall_cnt  <= fall_cnt + 4'd1;
        end
        if (enter_done) begin
          if (rise_cnt == 3'd6) oCFG <= cfg_shift;
          oFRAME_DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI-side model of the 8-channel, 12-bit serial ADC. It sits on the ADC pins (CONVST/CS, SCLK, DIN, DOUT) in place of the real converter for hardware-in-loop and bench testing of the ADC controller. It oversamples the master's signals on a fast local clock, decodes the 6-bit channel-configuration word, and shifts back 12-bit conversion results, MSB first, from a parallel data bus.

## Interface
- CONV_CYCLES, 65: minimum iCS-high time in iCLK cycles for a valid conversion (1.3 us at 50 MHz).
- RST_CFG, 6'b100010: configuration in effect after reset (single-ended, ch0, unipolar, no sleep).
- iCLK  in  1  local sampling clock; must be ≥ 8× the SCLK frequency.
- iRST_n  in  1  asynchronous, active-low reset.
- iCS  in  1  CONVST/CS from master; high = convert, low = shift frame.
- iSCLK  in  1  serial clock from master, asynchronous to iCLK.
- iDIN  in  1  config bits from master.
- oDOUT  out  1  serial result to master.
- iCH_DATA  in  96  channel n value at [12n+11:12n], unipolar binary.
- oCFG  out  6  last committed config {S/D, O/S, S1, S0, UNI, SLP}.
- oFRAME_DONE  out  1  one-cycle pulse when a complete frame ends.
- oCONV_ERR  out  1  one-cycle pulse when iCS was high for fewer than CONV_CYCLES.

## Operation
- iCS, iSCLK, iDIN each pass through a 2-flop synchronizer; edges are detected on the synchronized copies.
- States: IDLE, CONV, SHIFT, DONE.
  - Reset -> IDLE.
  - iCS rise in any state -> CONV. An unfinished SHIFT is aborted: no config commit, no oFRAME_DONE.
  - CONV: conv_cnt counts up, saturating at CONV_CYCLES.
  - iCS fall in CONV -> SHIFT.
  - 11th SCLK fall in SHIFT -> DONE.
  - DONE holds until the next iCS rise.
- On entry to SHIFT:
  - Channel = {O/S,S1,S0} of the committed oCFG. The configuration is pipelined: the config sent in frame N selects the data for frame N+1.
  - Sample = iCH_DATA slice for that channel.
  - If oCFG UNI=0 (bipolar), output sample ^ 12'h800 (offset binary to two's complement).
  - If conv_cnt < CONV_CYCLES: load 12'h000 and pulse oCONV_ERR.
  - Load the 12-bit shift register and drive bit 11 on oDOUT.
- SHIFT:
  - Each synchronized SCLK rise: if rise count < 6, shift iDIN into cfg_shift, MSB first.
  - Each SCLK fall: advance to the next lower bit. Bit 0 is driven after the 11th fall.
- DONE entry:
  - If 6 config bits were captured, commit cfg_shift to oCFG.
  - Pulse oFRAME_DONE.
  - oDOUT holds bit 0. Further SCLK edges are ignored.
- SLP and S/D are captured and reported only; they do not alter the data.
- IDLE/CONV: oDOUT = 0.

## Timing
- Reset values:
  - oDOUT = 0, oCFG = RST_CFG, oFRAME_DONE = 0, oCONV_ERR = 0.
  - Internal: conv_cnt = 0, cfg_shift = 0, bit counts = 0, state IDLE.
- Latency from pin edge to effect is 3 iCLK (2 sync + 1 register):
  - iCS fall -> MSB on oDOUT.
  - SCLK fall -> next bit on oDOUT.
  - SCLK rise -> iDIN captured.
- Master constraints:
  - SCLK high and low phases each ≥ 4 iCLK.
  - iCS fall to first SCLK rise ≥ 4 iCLK.
- oFRAME_DONE and oCFG update in the same cycle, 3 iCLK after the 11th SCLK fall pin edge.
- oCONV_ERR pulses 3 iCLK after the iCS fall pin edge.
- Simultaneous synchronized iCS rise and SCLK edge: iCS rise wins and the frame is aborted.
- iCH_DATA is sampled once per frame, on SHIFT entry; later changes do not affect that frame.
- Reset asserted mid-frame: everything returns to reset values immediately, and oCFG reverts to RST_CFG.

## Configuration
- ADC_RESP_RAMP_EN:
  - Defined: iCH_DATA is ignored. Sample = 12-bit ramp register, initially 0, incremented by 1 at each oFRAME_DONE and wrapping 4095 -> 0. UNI/bipolar conversion and the error zeroing still apply.
  - Undefined: the ramp register is absent and the sample comes from iCH_DATA.

## Test plan
- Reset state, first frame: reset released; iCS high 70 cycles; frame sending config 6'b111110 with ch0=12'hA5C -> oDOUT bits = 1010_0101_1100, oFRAME_DONE pulse, oCFG = 6'b111110.
- Pipelined channel select: next frame with ch7=12'h3F1 -> 12'h3F1 returned; oCFG unchanged if config is resent identically.
- Bipolar: config with UNI=0, then next frame with ch7=12'h000 -> 12'h800 returned.
- Short conversion: iCS high 20 cycles -> oCONV_ERR pulse, 12'h000 returned, config still committed after 11 SCLK.
- Abort: iCS rises after 3 SCLK -> no oFRAME_DONE, oCFG unchanged. Reset asserted mid-frame -> oDOUT=0, oCFG=6'b100010.
- ADC_RESP_RAMP_EN: 4097 frames -> returned values 0,1,…,4095,0.
